lsu_mem_initiator: RTL
======================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the pipeline MEM stage and the word-addressed data memory.
- Accepts one load/store request at a time and drives the memory's MemRead/MemWrite/inst/addr/data_in interface.
- Performs byte/halfword lane extraction with sign/zero extension on loads.
- Performs read-modify-write on sub-word stores, because the memory zero-fills the upper bits on byte/half writes.

Parameters:
ADDR_W, 5, memory word-address width; mem_addr = addr[ADDR_W+1:2]

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits significant for B/H
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result, valid with resp_valid
resp_err  out  1  misaligned-access flag, valid with resp_valid (MISALIGN_TRAP_EN only)
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_inst  out  3  to memory inst; always 010 (full word)
mem_addr  out  ADDR_W  word address to memory
mem_wdata  out  32  to memory data_in
mem_rdata  in  32  memory data_out, combinational from mem_addr

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_err=0. mem_read=0, mem_write=0, mem_inst=010, mem_addr=0, mem_wdata=0. All request registers cleared.
- Reset mid-operation aborts the access. No memory write issues in the cycle after reset.
- Handshake: a request is accepted at the edge where req_valid && req_ready. At that edge, funct3, addr, wdata and store are registered. The request inputs are ignored in every other state.
- States: IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP.
- IDLE, on accept:
  - load -> LOAD
  - store W -> ST_WORD
  - store B/H -> RMW_RD
- LOAD: mem_read=1, mem_addr from the registered addr. Extracted data captured at the clock edge -> RESP.
- ST_WORD: mem_write=1, mem_wdata=wdata -> RESP.
- RMW_RD: mem_read=1, old word captured -> RMW_WR.
- RMW_WR: mem_write=1. mem_wdata is the old word with the selected lane replaced:
  - B: lane addr[1:0], bits [8k+7:8k] = wdata[7:0]
  - H: lane addr[1], bits [16k+15:16k] = wdata[15:0]
  - Then -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
  - resp_rdata holds the load result until the next load completes.
  - On stores resp_rdata is unchanged.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: one request per 3 cycles (load/SW) or 4 cycles (SB/SH).
- mem_read and mem_write are never high together. Both are low in IDLE and RESP.
- Load extension:
  - B: sign-extend byte lane addr[1:0]
  - BU: zero-extend byte lane addr[1:0]
  - H: sign-extend half lane addr[1]
  - HU: zero-extend half lane addr[1]
  - W: full word
- Undefined funct3 (011, 110, 111): treated as W.
- Address wrap: byte-address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - H/HU with addr[0]=1, or W with addr[1:0]!=00, counts as misaligned.
  - Misaligned requests go IDLE -> RESP with no memory access (mem_read=mem_write=0).
  - resp_err=1 and resp_rdata unchanged, latency 1 cycle.
- Undefined:
  - Misaligned low bits are truncated: H uses addr[1], W uses addr[1:0]=00.
  - resp_err is tied to 0.

Test Plan:
- Preload mem[0]=0x0000_0011, mem[1]=0x0000_0009; LW addr 0x0 -> resp_valid 2 cycles after accept, resp_rdata=0x0000_0011, mem_write never high.
- mem[2]=0x80FF_7F01; LB 0x8 -> 0x0000_0001; LB 0xB -> 0xFFFF_FF80; LBU 0xB -> 0x0000_0080; LH 0xA -> 0xFFFF_80FF; LHU 0xA -> 0x0000_80FF.
- mem[1]=0x1122_3344; SB addr 0x5 wdata 0xAB -> RMW_RD then RMW_WR, mem[1]=0x1122_AB44, resp_valid 3 cycles after accept; SH addr 0x6 wdata 0xBEEF -> mem[1]=0xBEEF_AB44.
- Back-to-back req_valid held high with SW 0x0 then LW 0x0 -> second accept only after RESP; load returns the stored value; req_ready low in LOAD/ST_WORD/RMW/RESP.
- rst_n=0 asserted during RMW_RD of SB -> next cycle IDLE, mem_write never asserted, memory word unchanged, resp_valid=0.
- MISALIGN_TRAP_EN defined: LW addr 0x2 -> resp_valid after 1 cycle, resp_err=1, no mem_read. Undefined: the same request reads word 0 and resp_err=0.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Loads extract and sign/zero-extend a byte or halfword lane. Sub-word stores
// do read-modify-write because the memory zero-fills on narrow writes, so the
// memory is always driven with full-word accesses (mem_inst = 010).
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// H/HU/W requests skip the memory and complete with resp_err=1. When it is
// undefined, the misaligned low address bits are truncated and resp_err is 0.
module lsu_mem_initiator #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_inst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, and the request
  // inputs are ignored in every other state. resp_valid is a single-cycle
  // completion pulse; resp_rdata/resp_err are meaningful while it is high.

  typedef enum logic [2:0] {IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP} state_e;

  // funct3 decode: bit1 set -> word (also covers undefined 011/110/111),
  // otherwise bit0 picks half over byte, bit2 selects zero extension.
  state_e              state_q;
  logic                store_q;
  logic [2:0]          funct3_q;
  logic [1:0]          addr_lo_q;
  logic [15:0]         wdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic                req_misalign;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [31:0]         load_d;
  logic [4:0]          lane_shift;
  logic [31:0]         lane_mask;
  logic [31:0]         rmw_d;

  // Only the word-address bits of the byte address reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Misalignment detection on the incoming request (only when trapping).
  always_comb begin
    req_misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1]) req_misalign = (req_addr[1:0] != 2'b00);
    else               req_misalign = req_funct3[0] & req_addr[0];
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_byte  = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_half  = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    if (funct3_q[1])      load_d = mem_rdata;
    else if (funct3_q[0]) load_d = {{16{~funct3_q[2] & lane_half[15]}}, lane_half};
    else                  load_d = {{24{~funct3_q[2] & lane_byte[7]}}, lane_byte};
    lane_shift = funct3_q[0] ? {addr_lo_q[1], 4'b0000} : {addr_lo_q, 3'b000};
    lane_mask  = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    rmw_d      = (mem_rdata & ~lane_mask) | (({16'h0000, wdata_q} << lane_shift) & lane_mask);
  end

`ifdef MISALIGN_TRAP_EN
  logic resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Main FSM: sequences each access and registers every memory/response output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 16'h0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q     <= req_store;
            funct3_q    <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            mem_addr_q  <= req_addr[ADDR_W+1:2];
            req_ready_q <= 1'b0;
            if (req_misalign) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              resp_err_q   <= 1'b1;
`endif
            end else if (!req_store) begin
              state_q    <= LOAD;
              mem_read_q <= 1'b1;
            end else if (req_funct3[1]) begin
              state_q     <= ST_WORD;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          mem_read_q   <= 1'b0;
          if (!store_q) resp_rdata_q <= load_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        ST_WORD: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= rmw_d;
          state_q     <= RMW_WR;
        end
        RMW_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          req_ready_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
          resp_err_q  <= 1'b0;
`endif
          state_q     <= IDLE;
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_inst   = 3'b010;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule
